simmem_release_scheduler: RTL and testbench

Delay-timed release scheduler for the simulated memory controller's linked-list message bank. It accepts each message's RAM address as the bank stores it, together with a per-message delay in cycles. When delays expire, it drives the release address/valid pair back into the bank, oldest eligible first. It is the consumer-side counterpart of the bank: the bank writes messages, and this block decides when and which stored address is read out.

---
 rtl/simmem_release_scheduler.sv | 156 +++++++++++++++
 tb/tb_simmem_release_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_release_scheduler.sv
// Delay-timed release scheduler: holds bank addresses until their delay expires,
// then presents the oldest eligible address on a valid/ready release port.
module simmem_release_scheduler #(
    parameter int NumSlots      = 8,
    parameter int TotalCapacity = 128,
    parameter int DelayWidth    = 8,
    localparam int AW   = $clog2(TotalCapacity),
    localparam int OccW = $clog2(NumSlots + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [AW-1:0]         in_addr_i,
    input  logic [DelayWidth-1:0] in_delay_i,
    output logic                  release_valid_o,
    input  logic                  release_ready_i,
    output logic [AW-1:0]         release_addr_o,
    output logic [OccW-1:0]       occupancy_o
);

    localparam int IdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;

    typedef enum logic {S_IDLE, S_PRESENT} state_t;

    logic [NumSlots-1:0]   r_valid;
    logic [AW-1:0]         r_addr  [NumSlots];
    logic [DelayWidth-1:0] r_cnt   [NumSlots];
    logic [NumSlots-1:0]   r_older [NumSlots];   // r_older[i][j]: slot i accepted before slot j
    state_t                r_state;
    logic [IdxW-1:0]       r_sel;
    logic                  r_rel_valid;
    logic [AW-1:0]         r_rel_addr;
    logic [OccW-1:0]       r_occ;

    logic [NumSlots-1:0]   w_elig;
    logic [NumSlots-1:0]   w_mask;
    logic [NumSlots-1:0]   w_blocked;
    logic [IdxW-1:0]       w_pick_idx;
    logic                  w_pick_any;
    logic [IdxW-1:0]       w_free_idx;
    logic                  w_accept;
    logic                  w_release;

    // The slot under handshake is masked so a back-to-back pick never repeats it.
    always_comb begin
        w_elig     = '0;
        w_blocked  = '0;
        w_pick_idx = '0;
        w_free_idx = '0;
        for (int i = 0; i < NumSlots; i++) begin
            w_elig[i] = r_valid[i] && (r_cnt[i] == '0);
        end
        w_mask = w_elig;
        if (r_state == S_PRESENT) begin
            w_mask[r_sel] = 1'b0;
        end
        w_pick_any = |w_mask;
        for (int i = 0; i < NumSlots; i++) begin
            for (int j = 0; j < NumSlots; j++) begin
                if (w_mask[j] && r_older[j][i]) begin
                    w_blocked[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NumSlots; i++) begin
            if (w_mask[i] && !w_blocked[i]) begin
                w_pick_idx = IdxW'(i);
            end
        end
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = IdxW'(i);
            end
        end
    end

    assign in_ready_o      = ~&r_valid;
    assign w_accept        = in_valid_i && in_ready_o;
    assign w_release       = (r_state == S_PRESENT) && release_ready_i;
    assign release_valid_o = r_rel_valid;
    assign release_addr_o  = r_rel_addr;
    assign occupancy_o     = r_occ;

    // Addresses are pure payload; a slot's address is only read while it is valid.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_addr[w_free_idx] <= in_addr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid     <= '0;
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_rel_valid <= 1'b0;
            r_rel_addr  <= '0;
            r_occ       <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                r_cnt[i]   <= '0;
                r_older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                if (r_valid[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - DelayWidth'(1);
                end
            end
            if (w_accept) begin
                r_valid[w_free_idx] <= 1'b1;
                r_cnt[w_free_idx]   <= in_delay_i;
                r_older[w_free_idx] <= '0;
                for (int k = 0; k < NumSlots; k++) begin
                    r_older[k][w_free_idx] <= r_valid[k];
                end
            end
            // Release clears come last so they win over the age bits set by a same-cycle accept.
            if (w_release) begin
                r_valid[r_sel] <= 1'b0;
                r_older[r_sel] <= '0;
                for (int k = 0; k < NumSlots; k++) begin
                    r_older[k][r_sel] <= 1'b0;
                end
            end
            if (w_accept && !w_release) begin
                r_occ <= r_occ + OccW'(1);
            end else if (!w_accept && w_release) begin
                r_occ <= r_occ - OccW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pick_any) begin
                        r_sel       <= w_pick_idx;
                        r_rel_valid <= 1'b1;
                        r_rel_addr  <= r_addr[w_pick_idx];
                        r_state     <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (release_ready_i) begin
                        if (w_pick_any) begin
                            r_sel      <= w_pick_idx;
                            r_rel_addr <= r_addr[w_pick_idx];
                        end else begin
                            r_rel_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Bench for simmem_release_scheduler: directed table, corner sequences and a
// randomized run checked against a deadline/sequence-number queue model.
module tb_simmem_release_scheduler;

    localparam int NS = 8;
    localparam int TC = 128;
    localparam int DW = 8;
    localparam int AW = 7;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_delay;
    logic          rel_valid;
    logic          rel_ready;
    logic [AW-1:0] rel_addr;
    logic [OW-1:0] occ;

    always #5 clk = ~clk;

    simmem_release_scheduler #(
        .NumSlots(NS), .TotalCapacity(TC), .DelayWidth(DW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_addr_i(in_addr), .in_delay_i(in_delay),
        .release_valid_o(rel_valid), .release_ready_i(rel_ready),
        .release_addr_o(rel_addr), .occupancy_o(occ)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: entries carry an acceptance sequence number (age) and an
    // absolute cycle at which they become eligible.
    typedef struct {int addr; int seq; int ready_at;} ent_t;
    ent_t m_q[$];
    int   m_cyc, m_seq, m_pres_seq, m_pres_addr;
    bit   m_pres;

    function automatic int m_pick();
        int best = -1;
        for (int i = 0; i < m_q.size(); i++)
            if (m_q[i].ready_at <= m_cyc && (best < 0 || m_q[i].seq < m_q[best].seq)) best = i;
        return best;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_cyc = 0; m_seq = 0; m_pres = 1'b0; m_pres_seq = -1; m_pres_addr = 0;
    endtask

    task automatic m_edge(input bit v, input int a, input int d, input bit r);
        bit acc;
        int p;
        acc = v && (m_q.size() < NS);
        if (!m_pres) begin
            p = m_pick();
            if (p >= 0) begin
                m_pres = 1'b1; m_pres_seq = m_q[p].seq; m_pres_addr = m_q[p].addr;
            end
        end else if (r) begin
            for (int i = 0; i < m_q.size(); i++)
                if (m_q[i].seq == m_pres_seq) begin m_q.delete(i); break; end
            p = m_pick();
            if (p >= 0) begin
                m_pres_seq = m_q[p].seq; m_pres_addr = m_q[p].addr;
            end else begin
                m_pres = 1'b0;
            end
        end
        m_cyc++;
        if (acc) begin
            m_q.push_back('{a, m_seq, m_cyc + d});
            m_seq++;
        end
    endtask

    task automatic step(input bit v, input int a, input int d, input bit r);
        in_valid  = v;
        in_addr   = AW'(a);
        in_delay  = DW'(d);
        rel_ready = r;
        @(posedge clk);
        m_edge(v, a, d, r);
        #1;
        chk("model_rv", 32'(rel_valid), 32'(m_pres));
        if (m_pres) chk("model_addr", 32'(rel_addr), 32'(m_pres_addr));
        chk("model_in_ready", 32'(in_ready), 32'(m_q.size() < NS));
        chk("model_occ", 32'(occ), 32'(m_q.size()));
    endtask

    task automatic do_reset();
        in_valid = 1'b0; rel_ready = 1'b0; in_addr = '0; in_delay = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    typedef struct {
        bit v; int a; int d; bit r;
        bit e_rv; int e_addr; int e_occ; bit e_rdy;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int ec;
        bit got;
        tbl[0] = '{1'b1, 5, 3, 1'b0, 1'b0, 0, 1, 1'b1};
        tbl[1] = '{1'b0, 0, 0, 1'b0, 1'b0, 0, 1, 1'b1};
        tbl[2] = '{1'b0, 0, 0, 1'b0, 1'b0, 0, 1, 1'b1};
        tbl[3] = '{1'b0, 0, 0, 1'b0, 1'b0, 0, 1, 1'b1};
        tbl[4] = '{1'b0, 0, 0, 1'b0, 1'b1, 5, 1, 1'b1};
        tbl[5] = '{1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 1'b1};
        tbl[6] = '{1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; rel_ready = 1'b0; in_addr = '0; in_delay = '0;
        m_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("reset_rv", 32'(rel_valid), 0);
        chk("reset_addr", 32'(rel_addr), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_occ", 32'(occ), 0);
        rst = 1'b0;

        // Single entry: addr 5, delay 3
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_rv", i), 32'(rel_valid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_addr", i), 32'(rel_addr), 32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_occ", i), 32'(occ), 32'(tbl[i].e_occ));
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
        end

        // Ordering by delay
        do_reset();
        step(1'b1, 1, 10, 1'b1);
        step(1'b1, 2, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        chk("dly_b_rv", 32'(rel_valid), 1);
        chk("dly_b_addr", 32'(rel_addr), 2);
        step(1'b0, 0, 0, 1'b1);
        chk("dly_b_gone", 32'(rel_valid), 0);
        chk("dly_occ", 32'(occ), 1);
        ec = 3; got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step(1'b0, 0, 0, 1'b0);
            ec++;
            if (rel_valid) got = 1'b1;
        end
        chk("dly_a_seen", 32'(got), 1);
        chk("dly_a_cycle", 32'(ec), 11);
        chk("dly_a_addr", 32'(rel_addr), 1);

        // Ordering by age, back-to-back
        do_reset();
        step(1'b1, 10, 0, 1'b0);
        step(1'b1, 11, 0, 1'b0);
        step(1'b1, 12, 0, 1'b0);
        chk("age_first", 32'(rel_addr), 10);
        chk("age_occ", 32'(occ), 3);
        step(1'b0, 0, 0, 1'b1);
        chk("age_second_rv", 32'(rel_valid), 1);
        chk("age_second", 32'(rel_addr), 11);
        step(1'b0, 0, 0, 1'b1);
        chk("age_third_rv", 32'(rel_valid), 1);
        chk("age_third", 32'(rel_addr), 12);
        step(1'b0, 0, 0, 1'b1);
        chk("age_done_rv", 32'(rel_valid), 0);
        chk("age_done_occ", 32'(occ), 0);

        // Stability under backpressure
        do_reset();
        step(1'b1, 3, 4, 1'b0);
        step(1'b1, 7, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        chk("stab_first", 32'(rel_addr), 7);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 0, 0, 1'b0);
            chk("stab_hold_rv", 32'(rel_valid), 1);
            chk("stab_hold_addr", 32'(rel_addr), 7);
        end
        step(1'b0, 0, 0, 1'b1);
        chk("stab_next_rv", 32'(rel_valid), 1);
        chk("stab_next_addr", 32'(rel_addr), 3);
        step(1'b0, 0, 0, 1'b1);
        chk("stab_empty", 32'(occ), 0);

        // Full
        do_reset();
        for (int i = 0; i < NS; i++) step(1'b1, 20 + i, (i == 0) ? 0 : 200, 1'b0);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_occ", 32'(occ), 8);
        step(1'b1, 99, 0, 1'b0);
        chk("full_ignored_occ", 32'(occ), 8);
        chk("full_ignored_rdy", 32'(in_ready), 0);
        step(1'b0, 0, 0, 1'b1);
        chk("full_rel_occ", 32'(occ), 7);
        chk("full_rel_in_ready", 32'(in_ready), 1);

        // Simultaneous accept and release
        do_reset();
        step(1'b1, 40, 0, 1'b0);
        step(1'b1, 41, 100, 1'b0);
        chk("sim_pre_occ", 32'(occ), 2);
        chk("sim_pre_addr", 32'(rel_addr), 40);
        step(1'b1, 42, 100, 1'b1);
        chk("sim_post_occ", 32'(occ), 2);
        chk("sim_post_rv", 32'(rel_valid), 0);

        // Asynchronous reset while presenting
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 50 + i, 0, 1'b0);
        chk("mrst_pre_rv", 32'(rel_valid), 1);
        chk("mrst_pre_occ", 32'(occ), 4);
        rst = 1'b1;
        #1;
        chk("mrst_rv", 32'(rel_valid), 0);
        chk("mrst_addr", 32'(rel_addr), 0);
        chk("mrst_occ", 32'(occ), 0);
        chk("mrst_in_ready", 32'(in_ready), 1);
        m_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 0, 0, 1'b1);
            chk("mrst_no_stale", 32'(rel_valid), 0);
        end

        // Randomized run against the model
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 127),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 5),
                 $urandom_range(0, 99) < 70);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
